// File: rtl/program_loader.sv
//==============================================================================
// Module      : program_loader
// Description : Streams headers and payload words into instruction/data memory,
//               then starts the cpu and counts its enabled cycles until stop.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        stop,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic [31:0] run_cycles
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_I    = 3'd1,
      LOAD_D_LO = 3'd2,
      LOAD_D_HI = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [31:0] c_cycles_max = 32'hFFFF_FFFF;

   state_t      r_state;
   state_t      w_state_next;
   logic [11:0] r_base;
   logic [15:0] r_count;
   logic [15:0] r_idx;
   logic [31:0] r_lo;
   logic        r_wen;
   logic [63:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_wen_2;
   logic [63:0] r_addr_2;
   logic [63:0] r_wdata_2;
   logic [31:0] r_run_cycles;

   logic        w_accept;
   logic        w_last;
   logic [28:0] w_word;

   // Word index is widened before the add so B+i never wraps.
   assign w_word   = 29'(r_base) + 29'(r_idx);
   assign w_last   = (r_idx == (r_count - 16'd1));
   assign in_ready = ~rst & (r_state != RUN);
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (in_data[30]) begin
                  w_state_next = RUN;
               end else if (in_data[15:0] != 16'd0) begin
                  w_state_next = in_data[31] ? LOAD_D_LO : LOAD_I;
               end
            end
         end
         LOAD_I: begin
            if (w_accept && w_last) w_state_next = IDLE;
         end
         LOAD_D_LO: begin
            if (w_accept) w_state_next = LOAD_D_HI;
         end
         LOAD_D_HI: begin
            if (w_accept) w_state_next = w_last ? IDLE : LOAD_D_LO;
         end
         RUN: begin
            if (stop) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base       <= '0;
         r_count      <= '0;
         r_idx        <= '0;
         r_lo         <= '0;
         r_wen        <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wen_2      <= 1'b0;
         r_addr_2     <= '0;
         r_wdata_2    <= '0;
         r_run_cycles <= '0;
      end else begin
         r_wen   <= 1'b0;
         r_wen_2 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (in_data[30]) begin
                     r_run_cycles <= '0;
                  end else if (in_data[15:0] != 16'd0) begin
                     r_base  <= in_data[27:16];
                     r_count <= in_data[15:0];
                     r_idx   <= '0;
                  end
               end
            end
            LOAD_I: begin
               if (w_accept) begin
                  r_wen   <= 1'b1;
                  r_addr  <= {33'd0, w_word, 2'b00};
                  r_wdata <= in_data;
                  r_idx   <= r_idx + 16'd1;
               end
            end
            LOAD_D_LO: begin
               if (w_accept) r_lo <= in_data;
            end
            LOAD_D_HI: begin
               if (w_accept) begin
                  r_wen_2   <= 1'b1;
                  r_addr_2  <= {32'd0, w_word, 3'b000};
                  r_wdata_2 <= {in_data, r_lo};
                  r_idx     <= r_idx + 16'd1;
               end
            end
            RUN: begin
               // The cycle in which stop is sampled was still an enabled cycle.
               if (r_run_cycles != c_cycles_max) r_run_cycles <= r_run_cycles + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign addr_ext    = r_addr;
   assign wen_ext     = r_wen;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = r_wdata;
   assign addr_ext_2  = r_addr_2;
   assign wen_ext_2   = r_wen_2;
   assign ren_ext_2   = 1'b0;
   assign wdata_ext_2 = r_wdata_2;
   assign cpu_enable  = (r_state == RUN);
   assign run_cycles  = r_run_cycles;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//==============================================================================
// Module      : tb_program_loader
// Description : Directed and randomized stimulus against a stream-level model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        stop;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic [31:0] run_cycles;

   always #5 clk = ~clk;

   program_loader dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .stop        (stop),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .cpu_enable  (cpu_enable),
      .run_cycles  (run_cycles)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Reference model: tracks the stream as "header expected" or "k words left".
   bit          m_run;
   int          m_left;
   bit          m_dmem;
   bit          m_half;
   logic [31:0] m_lo;
   int unsigned m_next;
   bit          m_wen, m_wen2;
   logic [63:0] m_addr, m_addr2, m_wd2;
   logic [31:0] m_wd;
   logic [31:0] m_cycles;

   task automatic m_reset();
      m_run = 0; m_left = 0; m_dmem = 0; m_half = 0; m_lo = '0; m_next = 0;
      m_wen = 0; m_wen2 = 0; m_addr = '0; m_addr2 = '0; m_wd = '0; m_wd2 = '0;
      m_cycles = '0;
   endtask

   task automatic m_step(input bit r, input bit v, input logic [31:0] d, input bit s);
      if (r) begin
         m_reset();
         return;
      end
      m_wen  = 0;
      m_wen2 = 0;
      if (m_run) begin
         if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
         if (s) m_run = 0;
      end else if (v) begin
         if (m_left == 0) begin
            if (d[30]) begin
               m_run = 1;
               m_cycles = '0;
            end else if (d[15:0] != 0) begin
               m_left = int'(d[15:0]);
               m_dmem = d[31];
               m_next = d[27:16];
               m_half = 0;
            end
         end else if (!m_dmem) begin
            m_wen  = 1;
            m_addr = 64'(m_next) * 64'd4;
            m_wd   = d;
            m_next++;
            m_left--;
         end else if (!m_half) begin
            m_lo   = d;
            m_half = 1;
         end else begin
            m_wen2  = 1;
            m_addr2 = 64'(m_next) * 64'd8;
            m_wd2   = {d, m_lo};
            m_half  = 0;
            m_next++;
            m_left--;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [31:0] d, input bit s);
      bit exp_ready;
      rst      = r;
      in_valid = v;
      in_data  = d;
      stop     = s;
      #1;
      exp_ready = !r && !m_run;
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      @(posedge clk);
      m_step(r, v && exp_ready, d, s);
      #1;
      check("wen_ext", 64'(wen_ext), 64'(m_wen));
      check("wen_ext_2", 64'(wen_ext_2), 64'(m_wen2));
      check("wen_excl", 64'(wen_ext & wen_ext_2), 64'd0);
      check("addr_ext", addr_ext, m_addr);
      check("wdata_ext", 64'(wdata_ext), 64'(m_wd));
      check("addr_ext_2", addr_ext_2, m_addr2);
      check("wdata_ext_2", wdata_ext_2, m_wd2);
      check("cpu_enable", 64'(cpu_enable), 64'(m_run));
      check("run_cycles", 64'(run_cycles), 64'(m_cycles));
      check("ren_tied", 64'({ren_ext, ren_ext_2}), 64'd0);
   endtask

   logic [31:0] hdr;
   logic [31:0] d;

   initial begin
      m_reset();
      // reset state
      cycle(1, 0, 0, 0);
      cycle(1, 1, 32'h4000_0000, 1);
      check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
      check("rst_run_cycles", 64'(run_cycles), 64'd0);
      check("rst_addr_ext", addr_ext, 64'd0);
      check("rst_wdata_ext_2", wdata_ext_2, 64'd0);

      // imem load of 3 words at base 2
      cycle(0, 1, 32'h0002_0003, 0);
      cycle(0, 1, 32'hAAAA_0001, 0);
      check("imem_a_wen", 64'(wen_ext), 64'd1);
      check("imem_a_addr", addr_ext, 64'd8);
      check("imem_a_data", 64'(wdata_ext), 64'hAAAA_0001);
      cycle(0, 1, 32'hBBBB_0002, 0);
      check("imem_b_addr", addr_ext, 64'd12);
      check("imem_b_data", 64'(wdata_ext), 64'hBBBB_0002);
      cycle(0, 1, 32'hCCCC_0003, 0);
      check("imem_c_addr", addr_ext, 64'd16);
      check("imem_c_data", 64'(wdata_ext), 64'hCCCC_0003);

      // dmem load, next beat is treated as a header
      cycle(0, 1, 32'h8005_0001, 0);
      check("imem_done_wen", 64'(wen_ext), 64'd0);
      cycle(0, 1, 32'h1111_1111, 0);
      check("dmem_lo_nowrite", 64'(wen_ext_2), 64'd0);
      cycle(0, 1, 32'h2222_2222, 0);
      check("dmem_wen", 64'(wen_ext_2), 64'd1);
      check("dmem_addr", addr_ext_2, 64'd40);
      check("dmem_data", wdata_ext_2, 64'h2222_2222_1111_1111);

      // zero count, then GO and stop
      cycle(0, 1, 32'h0000_0000, 0);
      check("zero_cnt_nowrite", 64'({wen_ext, wen_ext_2}), 64'd0);
      cycle(0, 1, 32'h4000_0000, 0);
      check("go_cpu_enable", 64'(cpu_enable), 64'd1);
      check("go_in_ready", 64'(in_ready), 64'd0);
      for (int k = 1; k <= 9; k++) cycle(0, k[0], 32'h0003_0002, 0);
      check("run_cycles_9", 64'(run_cycles), 64'd9);
      cycle(0, 1, 32'h0003_0002, 1);
      check("stop_cpu_enable", 64'(cpu_enable), 64'd0);
      check("stop_run_cycles", 64'(run_cycles), 64'd10);
      check("stop_in_ready", 64'(in_ready), 64'd1);
      cycle(0, 0, 0, 0);
      check("hold_run_cycles", 64'(run_cycles), 64'd10);

      // reset discards a half-assembled dmem word
      cycle(0, 1, 32'h8000_0001, 0);
      cycle(0, 1, 32'h5555_5555, 0);
      cycle(1, 0, 0, 0);
      cycle(0, 1, 32'h3333_0000, 0);
      check("rst_mid_no_wen2", 64'(wen_ext_2), 64'd0);
      cycle(0, 0, 0, 0);
      check("rst_mid_idle_wen2", 64'(wen_ext_2), 64'd0);

      // gaps in in_valid, stop ignored outside RUN
      cycle(0, 1, 32'h0010_0002, 1);
      cycle(0, 1, 32'hF00D_0001, 0);
      check("gap_a_addr", addr_ext, 64'd64);
      cycle(0, 0, 32'hDEAD_DEAD, 1);
      check("gap_idle_wen", 64'(wen_ext), 64'd0);
      cycle(0, 1, 32'hF00D_0002, 0);
      check("gap_b_wen", 64'(wen_ext), 64'd1);
      check("gap_b_addr", addr_ext, 64'd68);
      cycle(0, 0, 0, 1);
      check("idle_stop_cpu", 64'(cpu_enable), 64'd0);

      // high base index must carry past 12 bits
      cycle(0, 1, 32'h0FFF_0002, 0);
      cycle(0, 1, 32'h0000_00A1, 0);
      check("hi_base_addr0", addr_ext, 64'h3FFC);
      cycle(0, 1, 32'h0000_00A2, 0);
      check("hi_base_addr1", addr_ext, 64'h4000);
      cycle(0, 1, 32'h8FFF_0002, 0);
      cycle(0, 1, 32'h1, 0);
      cycle(0, 1, 32'h2, 0);
      check("hi_dmem_addr0", addr_ext_2, 64'h7FF8);
      cycle(0, 1, 32'h3, 0);
      cycle(0, 1, 32'h4, 0);
      check("hi_dmem_addr1", addr_ext_2, 64'h8000);
      check("hi_dmem_data1", wdata_ext_2, 64'h4_0000_0003);

      // randomized stream
      for (int n = 0; n < 4000; n++) begin
         int sel;
         bit r, v, s;
         sel = int'($urandom_range(0, 9));
         if (sel == 0) begin
            hdr = $urandom() | 32'h4000_0000;
         end else if (sel == 1) begin
            hdr = $urandom() & 32'hBFFF_0000;
         end else begin
            hdr = {$urandom_range(0, 1) == 1, 1'b0, 2'($urandom()), 12'($urandom()),
                   16'($urandom_range(1, 4))};
         end
         d = (!m_run && m_left == 0) ? hdr : $urandom();
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 3) != 0);
         s = m_run ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 3) == 0);
         cycle(r, v, d, s);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  main clock; single clock domain, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  load-stream beat valid
- in_ready  out  1  load-stream beat accept; a beat transfers when in_valid && in_ready at a rising edge
- in_data  in  32  load-stream word (header or payload)
- stop  in  1  halt request while running
- addr_ext  out  64  instruction-memory external byte address
- wen_ext  out  1  instruction-memory external write enable
- ren_ext  out  1  instruction-memory external read enable; tied 0
- wdata_ext  out  32  instruction-memory external write word
- addr_ext_2  out  64  data-memory external byte address
- wen_ext_2  out  1  data-memory external write enable
- ren_ext_2  out  1  data-memory external read enable; tied 0
- wdata_ext_2  out  64  data-memory external write word
- cpu_enable  out  1  drives the cpu enable input
- run_cycles  out  32  count of cycles with cpu_enable=1 since last GO

Function
REQ-002 FSM states SHALL be IDLE, LOAD_I, LOAD_D_LO, LOAD_D_HI and RUN.
REQ-003 in_ready SHALL be 1 in IDLE, LOAD_I, LOAD_D_LO and LOAD_D_HI, and 0 in RUN.
REQ-004 In IDLE, each accepted beat SHALL be decoded as a header with these fields: bit30 GO; bit31 target (0=imem, 1=dmem); bits[27:16] base word index B; bits[15:0] count N.
REQ-005 A header with GO=1 SHALL move the FSM to RUN, with cpu_enable=1 from the next cycle; all other header bits are ignored.
REQ-006 A header with GO=0 and N=0 SHALL leave the FSM in IDLE with no write.
REQ-007 A header with GO=0 and N>0 SHALL latch B and N, clear the word index i, and enter LOAD_I (target 0) or LOAD_D_LO (target 1).
REQ-008 LOAD_I: a beat accepted at edge t SHALL produce wen_ext=1 for exactly the cycle after t, with addr_ext=(B+i)*4 zero-extended to 64 bits and wdata_ext=in_data; i then increments.
REQ-009 LOAD_D_LO SHALL store in_data as the low word and move to LOAD_D_HI, with no write.
REQ-010 LOAD_D_HI: a beat accepted at edge t SHALL produce wen_ext_2=1 for exactly the cycle after t, with addr_ext_2=(B+i)*8 and wdata_ext_2={in_data, low word}; i then increments and the FSM returns to LOAD_D_LO.
REQ-011 When the write for i=N-1 is issued, the FSM SHALL return to IDLE on the same edge, so the next beat is a header.
REQ-012 Address arithmetic SHALL use at least 29 bits for B+i (12-bit B plus 16-bit i) before scaling, with no wrap.
REQ-013 wen_ext and wen_ext_2 SHALL never be high in the same cycle; the address and data outputs hold their last value when write enable is low.
REQ-014 RUN: cpu_enable=1; stop=1 at edge t SHALL give cpu_enable=0 from t+1 and return the FSM to IDLE.
REQ-015 stop outside RUN, and in_valid during RUN, SHALL be ignored.
REQ-016 run_cycles SHALL clear to 0 on GO acceptance, increment by 1 each cycle cpu_enable=1, saturate at 0xFFFFFFFF, and hold its value after stop.
REQ-017 Throughput SHALL be one payload beat per cycle with no bubbles between segments other than the header beat.

Reset
REQ-018 When rst=1 at an edge, state SHALL go to IDLE and in_ready to 0 for that cycle only (in_ready=1 from the first cycle after rst is released).
REQ-019 When rst=1 at an edge, wen_ext, wen_ext_2 and cpu_enable SHALL go to 0, and addr_ext, addr_ext_2, wdata_ext, wdata_ext_2, run_cycles, B, N, i and the low-word register SHALL go to 0.
REQ-020 rst SHALL take priority over all inputs; a partially loaded segment or half-assembled dmem word is discarded with no write.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- imem load: header 0x0002_0003, then 3 payload words A,B,C on consecutive cycles -> wen_ext pulses at addr 8, 12, 16 with data A,B,C; FSM then in IDLE.
- dmem load: header 0x8005_0001, then 0x1111_1111, 0x2222_2222 -> a single wen_ext_2 pulse, addr 40, data 0x2222_2222_1111_1111.
- zero count and GO: header 0x0000_0000 -> no write; then 0x4000_0000 -> cpu_enable=1 next cycle, in_ready=0; 10 cycles later run_cycles=10; stop -> cpu_enable=0, run_cycles stays 10, in_ready=1.
- reset mid-load: dmem header, low word accepted, rst pulse, then high word sent -> no wen_ext_2 ever; the word after rst is decoded as a header.
- backpressure/gaps: in_valid toggling 1,0,1,0 during an imem load of N=2 -> exactly 2 wen_ext pulses, one cycle after each accepted beat; stop asserted in IDLE has no effect.
